// File: rtl/regfile_wb_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_wb_arb_pkg;

  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned RegWidth     = 32;
  localparam logic [RegWidth-1:0] ZeroWord = '0;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Write-back request bundle: execute path (r0) and load path (r1).
interface regfile_wb_arb_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned REG_W      = 32
);

  logic                  r0_valid;
  logic [REG_ADDR_W-1:0] r0_addr;
  logic [REG_W-1:0]      r0_data;
  logic                  r0_ready;

  logic                  r1_valid;
  logic [REG_ADDR_W-1:0] r1_addr;
  logic [REG_W-1:0]      r1_data;
  logic                  r1_ready;

  modport master (
    output r0_valid, r0_addr, r0_data,
    output r1_valid, r1_addr, r1_data,
    input  r0_ready, r1_ready
  );

  modport slave (
    input  r0_valid, r0_addr, r0_data,
    input  r1_valid, r1_addr, r1_data,
    output r0_ready, r1_ready
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard with set-over-clear priority and two query ports.
// Only built when WB_ARB_SCOREBOARD_EN is defined.
`ifdef WB_ARB_SCOREBOARD_EN
module regfile_scoreboard
  import regfile_wb_arb_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic [REG_ADDR_W-1:0] q1_addr,
  input  logic [REG_ADDR_W-1:0] q2_addr,
  output logic                  q1_busy,
  output logic                  q2_busy
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_W;

  logic [NumRegs-1:1] busy_q, busy_d;
  logic [NumRegs-1:0] busy_vec, set_vec, clr_vec;
  logic               unused_bit0;

  // Bit 0 is dropped from the decoded vectors, so x0 can never become busy.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (clr_valid)   clr_vec[clr_addr]   = 1'b1;
    if (issue_valid) set_vec[issue_addr] = 1'b1;
    busy_d   = (busy_q & ~clr_vec[NumRegs-1:1]) | set_vec[NumRegs-1:1];
    busy_vec = {busy_q, 1'b0};
    q1_busy  = busy_vec[q1_addr] && !(clr_valid && (clr_addr == q1_addr));
    q2_busy  = busy_vec[q2_addr] && !(clr_valid && (clr_addr == q2_addr));
  end

  assign unused_bit0 = set_vec[0] ^ clr_vec[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

endmodule
`endif

// File: rtl/regfile_wb_arb.sv
// Round-robin write-back arbiter driving the register file's single write port.
// Optional busy scoreboard enabled by WB_ARB_SCOREBOARD_EN.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrWidth,
  parameter int unsigned REG_W      = RegWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arb_if.slave       req,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic [REG_ADDR_W-1:0] q1_addr,
  input  logic [REG_ADDR_W-1:0] q2_addr,
  output logic                  q1_busy,
  output logic                  q2_busy,
  output logic                  w_enable,
  output logic [REG_ADDR_W-1:0] w_addr,
  output logic [REG_W-1:0]      w_data
);

  req_e                  last_grant_q, last_grant_d;
  logic                  w_enable_q, w_enable_d;
  logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [REG_W-1:0]      w_data_q, w_data_d;
  logic                  r0_ready, r1_ready;

  // Ready is gated by reset so all outputs read 0 while reset is held.
  always_comb begin
    r0_ready     = rst && req.r0_valid && (!req.r1_valid || (last_grant_q == REQ_MEM));
    r1_ready     = rst && req.r1_valid && (!req.r0_valid || (last_grant_q == REQ_EX));
    last_grant_d = last_grant_q;
    w_enable_d   = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    if (r0_ready) begin
      last_grant_d = REQ_EX;
      w_enable_d   = (req.r0_addr != '0);
      w_addr_d     = req.r0_addr;
      w_data_d     = req.r0_data;
    end else if (r1_ready) begin
      last_grant_d = REQ_MEM;
      w_enable_d   = (req.r1_addr != '0);
      w_addr_d     = req.r1_addr;
      w_data_d     = req.r1_data;
    end
  end

  assign req.r0_ready = r0_ready;
  assign req.r1_ready = r1_ready;

  // Reset records MEM as last winner so the execute path is favoured first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ_MEM;
      w_enable_q   <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= REG_W'(ZeroWord);
    end else begin
      last_grant_q <= last_grant_d;
      w_enable_q   <= w_enable_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
    end
  end

  assign w_enable = w_enable_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;

`ifdef WB_ARB_SCOREBOARD_EN
  regfile_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .clr_valid  (w_enable_q),
    .clr_addr   (w_addr_q),
    .q1_addr    (q1_addr),
    .q2_addr    (q2_addr),
    .q1_busy    (q1_busy),
    .q2_busy    (q2_busy)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{issue_valid, issue_addr, q1_addr, q2_addr};
  assign q1_busy   = 1'b0;
  assign q2_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed self-checking bench for regfile_wb_arb (scoreboard checks follow WB_ARB_SCOREBOARD_EN).
module tb_regfile_wb_arb;

`ifdef WB_ARB_SCOREBOARD_EN
  localparam logic SB_EN = 1'b1;
`else
  localparam logic SB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid;
  logic [4:0]  issue_addr, q1_addr, q2_addr;
  logic        q1_busy, q2_busy, w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  int          checks = 0;
  int          errors = 0;

  regfile_wb_arb_if #(.REG_ADDR_W(5), .REG_W(32)) bus ();

  regfile_wb_arb #(.REG_ADDR_W(5), .REG_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .q1_addr    (q1_addr),
    .q2_addr    (q2_addr),
    .q1_busy    (q1_busy),
    .q2_busy    (q2_busy),
    .w_enable   (w_enable),
    .w_addr     (w_addr),
    .w_data     (w_data)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.r0_valid = 1'b0; bus.r0_addr = '0; bus.r0_data = '0;
    bus.r1_valid = 1'b0; bus.r1_addr = '0; bus.r1_data = '0;
    issue_valid  = 1'b0; issue_addr  = '0;
    q1_addr      = '0;   q2_addr     = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    #1;
    checks++; if (w_enable !== 1'b0) begin errors++; $display("FAIL reset_w_enable got %0h want 0", w_enable); end
    checks++; if (w_addr !== 5'd0) begin errors++; $display("FAIL reset_w_addr got %0h want 0", w_addr); end
    checks++; if (w_data !== 32'd0) begin errors++; $display("FAIL reset_w_data got %0h want 0", w_data); end
    checks++; if ({bus.r0_ready, bus.r1_ready, q1_busy, q2_busy} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {bus.r0_ready, bus.r1_ready, q1_busy, q2_busy});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_contention();
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_addr = ((i - 1) % 2 == 0) ? 5'd1 : 5'd2;
        exp_data = ((i - 1) % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222;
        checks++; if (w_enable !== 1'b1 || w_addr !== exp_addr || w_data !== exp_data) begin
          errors++; $display("FAIL contention_write%0d got en=%0h addr=%0d data=%0h want en=1 addr=%0d data=%0h",
                             i - 1, w_enable, w_addr, w_data, exp_addr, exp_data);
        end
      end
      if (i == 4) break;
      bus.r0_valid = 1'b1; bus.r0_addr = 5'd1; bus.r0_data = 32'h1111_1111;
      bus.r1_valid = 1'b1; bus.r1_addr = 5'd2; bus.r1_data = 32'h2222_2222;
      #1;
      checks++; if ({bus.r0_ready, bus.r1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL contention_grant%0d got r0r1=%b want %b", i,
                           {bus.r0_ready, bus.r1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    drive_idle();
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_addr = 5'd5; bus.r0_data = 32'hDEAD_BEEF;
    #1;
    checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got r0r1=%b want 10", {bus.r0_ready, bus.r1_ready});
    end
    @(negedge clk);
    checks++; if (w_enable !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write got en=%0h addr=%0d data=%0h want en=1 addr=5 data=deadbeef", w_enable, w_addr, w_data);
    end
    bus.r0_valid = 1'b0;
    @(negedge clk);
    checks++; if (w_enable !== 1'b0 || w_addr !== 5'd5 || w_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_hold got en=%0h addr=%0d data=%0h want en=0 addr=5 data=deadbeef", w_enable, w_addr, w_data);
    end
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    bus.r1_valid = 1'b1; bus.r1_addr = 5'd0; bus.r1_data = 32'h0000_1234;
    #1;
    checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin
      errors++; $display("FAIL x0_ready got r0r1=%b want 01", {bus.r0_ready, bus.r1_ready});
    end
    @(negedge clk);
    checks++; if (w_enable !== 1'b0 || w_data !== 32'h0000_1234) begin
      errors++; $display("FAIL x0_write got en=%0h data=%0h want en=0 data=1234", w_enable, w_data);
    end
    bus.r0_valid = 1'b1; bus.r0_addr = 5'd9;  bus.r0_data = 32'h0000_0009;
    bus.r1_valid = 1'b1; bus.r1_addr = 5'd10; bus.r1_data = 32'h0000_000A;
    #1;
    checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      errors++; $display("FAIL x0_ptr_advance got r0r1=%b want 10", {bus.r0_ready, bus.r1_ready});
    end
    @(negedge clk);
    checks++; if (w_enable !== 1'b1 || w_addr !== 5'd9) begin
      errors++; $display("FAIL x0_follow_write got en=%0h addr=%0d want en=1 addr=9", w_enable, w_addr);
    end
    bus.r0_valid = 1'b0;
    #1;
    checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b01) begin
      errors++; $display("FAIL x0_r1_after got r0r1=%b want 01", {bus.r0_ready, bus.r1_ready});
    end
    @(negedge clk);
    checks++; if (w_enable !== 1'b1 || w_addr !== 5'd10 || w_data !== 32'h0000_000A) begin
      errors++; $display("FAIL x0_r1_write got en=%0h addr=%0d data=%0h want en=1 addr=10 data=a", w_enable, w_addr, w_data);
    end
    drive_idle();
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd7; q1_addr = 5'd7; q2_addr = 5'd8;
    #1;
    checks++; if (q1_busy !== 1'b0) begin errors++; $display("FAIL sb_before_issue got %0h want 0", q1_busy); end
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd0;
    checks++; if (q1_busy !== SB_EN || q2_busy !== 1'b0) begin
      errors++; $display("FAIL sb_busy_set got q1=%0h q2=%0h want q1=%0h q2=0", q1_busy, q2_busy, SB_EN);
    end
    bus.r0_valid = 1'b1; bus.r0_addr = 5'd7; bus.r0_data = 32'h0000_0077;
    @(negedge clk);
    issue_valid = 1'b0;
    bus.r0_valid = 1'b0;
    checks++; if (w_enable !== 1'b1 || w_addr !== 5'd7 || q1_busy !== 1'b0) begin
      errors++; $display("FAIL sb_forward_qual got en=%0h addr=%0d q1=%0h want en=1 addr=7 q1=0", w_enable, w_addr, q1_busy);
    end
    q2_addr = 5'd0;
    @(negedge clk);
    checks++; if (q1_busy !== 1'b0 || q2_busy !== 1'b0) begin
      errors++; $display("FAIL sb_cleared got q1=%0h q2(x0)=%0h want 0 0", q1_busy, q2_busy);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd7; q1_addr = 5'd7;
    @(negedge clk);
    issue_valid = 1'b0;
    bus.r0_valid = 1'b1; bus.r0_addr = 5'd7; bus.r0_data = 32'h0000_0777;
    @(negedge clk);
    bus.r0_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd7;
    checks++; if (w_enable !== 1'b1 || q1_busy !== 1'b0) begin
      errors++; $display("FAIL collide_pre got en=%0h q1=%0h want en=1 q1=0", w_enable, q1_busy);
    end
    @(negedge clk);
    issue_valid = 1'b0;
    checks++; if (w_enable !== 1'b0 || q1_busy !== SB_EN) begin
      errors++; $display("FAIL collide_set_wins got en=%0h q1=%0h want en=0 q1=%0h", w_enable, q1_busy, SB_EN);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 5'd3; q1_addr = 5'd3;
    @(negedge clk);
    issue_valid = 1'b0;
    bus.r0_valid = 1'b1; bus.r0_addr = 5'd4; bus.r0_data = 32'h0000_CAFE;
    @(negedge clk);
    checks++; if (w_enable !== 1'b1 || q1_busy !== SB_EN) begin
      errors++; $display("FAIL rstmid_pre got en=%0h q1=%0h want en=1 q1=%0h", w_enable, q1_busy, SB_EN);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (w_enable !== 1'b0 || w_addr !== 5'd0 || w_data !== 32'd0 || q1_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_async got en=%0h addr=%0d data=%0h q1=%0h want all 0", w_enable, w_addr, w_data, q1_busy);
    end
    checks++; if (bus.r0_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %0h want 0", bus.r0_ready); end
    @(negedge clk);
    rst = 1'b1;
    bus.r0_valid = 1'b1; bus.r0_addr = 5'd1;
    bus.r1_valid = 1'b1; bus.r1_addr = 5'd2;
    #1;
    checks++; if ({bus.r0_ready, bus.r1_ready} !== 2'b10) begin
      errors++; $display("FAIL rstmid_grant got r0r1=%b want 10", {bus.r0_ready, bus.r1_ready});
    end
    checks++; if (q1_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy3 got %0h want 0", q1_busy); end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_x0_write();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
# regfile_wb_arb

Write-back arbiter and scoreboard for the single-write-port integer register file. Two producers share the register file's one write port: the execute path (requester 0) and the load/memory path (requester 1). Each uses a valid/ready handshake, and the grants alternate round-robin. Grants become a registered w_enable/w_addr/w_data triple that drives the register file directly. A per-register busy scoreboard marks destinations at issue and clears them at write-back, so decode can stall on operands that are still pending.

## Interface
- REG_ADDR_W, 5, register address width (32 registers)
- REG_W, 32, register data width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- r0_valid  in  1  execute-path write-back request
- r0_addr  in  REG_ADDR_W  execute-path destination
- r0_data  in  REG_W  execute-path result
- r0_ready  out  1  execute-path request accepted this cycle
- r1_valid / r1_addr / r1_data / r1_ready: same as r0_*, for the load path
- issue_valid  in  1  an instruction with a destination issues this cycle
- issue_addr  in  REG_ADDR_W  destination of the issuing instruction
- q1_addr, q2_addr  in  REG_ADDR_W  operand addresses queried by decode
- q1_busy, q2_busy  out  1  the queried register has an outstanding write
- w_enable  out  1  register-file write enable (registered)
- w_addr  out  REG_ADDR_W  register-file write address (registered)
- w_data  out  REG_W  register-file write data (registered)

## Operation
- **Handshake.**
  - A transfer occurs when rN_valid && rN_ready.
  - Once asserted, rN_valid/addr/data hold stable until the transfer completes; a request is never withdrawn.
- **Arbitration.**
  - At most one ready is asserted per cycle.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester not granted most recently wins.
  - The last-grant pointer updates only on a transfer.
- **Ready timing.**
  - Ready is combinational from the valids and the pointer.
  - There is no output back-pressure; the register file always accepts a write.
- **Write issue.**
  - On a transfer, the next edge loads w_addr/w_data from the winner and sets w_enable = 1.
  - With no transfer, w_enable = 0 and w_addr/w_data hold their previous values.
- **Writes to x0.**
  - The transfer is accepted (ready asserted as normal).
  - The registered w_enable is forced to 0.
  - The pointer still advances.
- **Scoreboard.**
  - busy[1..31] is a set of flops; busy[0] is a constant 0.
  - Set: issue_valid at issue_addr, with issue_addr != 0.
  - Clear: at the edge after w_enable is high for w_addr.
  - Set and clear of the same address on the same edge: set wins (a new producer has issued).
- **Query.**
  - qN_busy = busy[qN_addr] && !(w_enable && w_addr == qN_addr).
  - The qualifier is needed because the register file forwards the write in progress.
  - A query of x0 always returns 0.
- **Reset** (asynchronous, at any time): w_enable = 0, w_addr = 0, w_data = 0, busy = all 0, pointer = favour requester 0. Any transfer in flight is dropped.

## Timing
- Accept-to-write latency is 1 cycle: a transfer at edge N gives w_enable high during cycle N+1, and the register file captures the data at edge N+2.
- Throughput is one write per cycle.
- Under continuous dual requests, grants alternate 0,1,0,1, so each requester waits at most 1 cycle.
- Issue-to-busy latency is 1 cycle: qN_busy rises the cycle after issue_valid.
- All outputs are 0 during reset. r0_ready and r1_ready are 0 whenever their valid is 0.

## Configuration
- Macro: WB_ARB_SCOREBOARD_EN.
- Defined: the scoreboard is built as described above.
- Undefined:
  - No busy flops are built and issue_valid/issue_addr are ignored.
  - q1_busy and q2_busy are tied to 0; decode relies on forwarding alone.
  - Arbitration and the write port are unchanged.

## Structure
- The shared package holds: RegAddrWidth, RegWidth, ZeroWord, and the requester index encoding (REQ_EX = 0, REQ_MEM = 1).
- Sub-module regfile_scoreboard holds the busy flops, the set/clear priority, and the two query ports.
  - It is instantiated only under WB_ARB_SCOREBOARD_EN.
- The top level holds the round-robin pointer, the grant logic, and the output registers.

## Test plan
- **Single requester:** r0_valid=1, addr=5, data=0xDEADBEEF, with r1 idle.
  - r0_ready=1 the same cycle.
  - Next cycle: w_enable=1, w_addr=5, w_data=0xDEADBEEF.
- **Contention:** both valid for 4 cycles (r0 addr 1, r1 addr 2) with the pointer at reset.
  - Grants go r0, r1, r0, r1.
  - w_addr sequence is 1, 2, 1, 2.
- **x0 write:** r1_valid=1, addr=0, data=0x1234.
  - r1_ready=1, but w_enable stays 0.
  - The pointer advances: a following dual request grants r0.
- **Scoreboard:** issue_valid with addr=7.
  - Next cycle: q1_addr=7 gives q1_busy=1.
  - A later r0 write to 7: q1_busy=0 during the w_enable cycle, and it stays 0 afterwards.
- **Set/clear collision:** issue_addr=7 on the same edge busy[7] is being cleared.
  - busy[7] remains 1.
- **Reset mid-operation:** assert rst low while w_enable=1 and busy[3]=1.
  - Immediately: w_enable=0, w_addr=0, w_data=0, q_busy for 3 is 0.
  - After release, a dual request grants r0.
